// File: rtl/display_arbiter.sv
// Display arbiter: grants one of three sources ownership of a 4-digit display path,
// round-robin among requesters, with a minimum hold time per grant and clamped data.
module display_arbiter #(
  parameter int unsigned HOLD_CYC = 100,
  parameter int unsigned MAX_VAL  = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [13:0] data0,
  input  logic [13:0] data1,
  input  logic [13:0] data2,
  output logic [2:0]  grant,
  output logic [13:0] disp_data,
  output logic        disp_blank,
  output logic        busy
);

  localparam int unsigned     CntW    = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HOLD_CYC - 1);
  // Saturate the clamp limit to what a 14-bit value can carry.
  localparam logic [13:0]     MaxV    = (MAX_VAL > 16383) ? 14'h3fff : 14'(MAX_VAL);

  typedef enum logic [1:0] {StIdle, StLoad, StHold} state_e;

  state_e          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [13:0]     disp_data_q, disp_data_d;
  logic            disp_blank_q, disp_blank_d;
  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      last_owner_q, last_owner_d;

  logic [1:0]      cand [3];
  logic            rr_found;
  logic [1:0]      rr_idx;
  logic [2:0]      rr_onehot;

  logic [1:0]      owner_idx;
  logic [13:0]     owner_data;
  logic            owner_req;

  function automatic logic [13:0] clamp(input logic [13:0] v);
    return (v > MaxV) ? MaxV : v;
  endfunction

  // Round-robin search starting one past the last owner, wrapping back to it last.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = 2'd0;
    unique case (last_owner_q)
      2'd0: begin
        cand[0] = 2'd1;
        cand[1] = 2'd2;
        cand[2] = 2'd0;
      end
      2'd1: begin
        cand[0] = 2'd2;
        cand[1] = 2'd0;
        cand[2] = 2'd1;
      end
      default: begin
        cand[0] = 2'd0;
        cand[1] = 2'd1;
        cand[2] = 2'd2;
      end
    endcase
    for (int k = 0; k < 3; k++) begin
      if (!rr_found && req[cand[k]]) begin
        rr_found = 1'b1;
        rr_idx   = cand[k];
      end
    end
    rr_onehot = 3'b001 << rr_idx;
  end

  // Decode the current owner's index, data and request from the one-hot grant.
  always_comb begin
    owner_idx  = 2'd0;
    owner_data = data0;
    owner_req  = 1'b0;
    case (grant_q)
      3'b001: begin
        owner_idx  = 2'd0;
        owner_data = data0;
        owner_req  = req[0];
      end
      3'b010: begin
        owner_idx  = 2'd1;
        owner_data = data1;
        owner_req  = req[1];
      end
      3'b100: begin
        owner_idx  = 2'd2;
        owner_data = data2;
        owner_req  = req[2];
      end
      default: ;
    endcase
  end

  // Next-state logic for the arbitration FSM and its registered outputs.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    disp_data_d  = disp_data_q;
    disp_blank_d = disp_blank_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d = rr_onehot;
          state_d = StLoad;
        end else begin
          grant_d = '0;
        end
      end
      StLoad: begin
        disp_data_d  = clamp(owner_data);
        disp_blank_d = 1'b0;
        cnt_d        = '0;
        last_owner_d = owner_idx;
        state_d      = StHold;
      end
      StHold: begin
        // Refresh only while the owner still asks; otherwise the last sample stays frozen.
        if (owner_req) disp_data_d = clamp(owner_data);
        if (cnt_q == CntLast) begin
          if (!rr_found) begin
            grant_d = '0;
            state_d = StIdle;
          end else if (rr_onehot != grant_q) begin
            // Hand over directly, no zero-grant gap.
            grant_d = rr_onehot;
            state_d = StLoad;
          end else begin
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        grant_d = '0;
        state_d = StIdle;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      disp_data_q  <= '0;
      disp_blank_q <= 1'b1;
      busy_q       <= 1'b0;
      cnt_q        <= '0;
      last_owner_q <= 2'd2;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      disp_data_q  <= disp_data_d;
      disp_blank_q <= disp_blank_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign grant      = grant_q;
  assign disp_data  = disp_data_q;
  assign disp_blank = disp_blank_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYC = 4, MAX_VAL = 9999.
module tb_display_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [13:0] data0, data1, data2;
  logic [2:0]  grant;
  logic [13:0] disp_data;
  logic        disp_blank;
  logic        busy;

  int checks = 0;
  int errors = 0;

  display_arbiter #(
    .HOLD_CYC (4),
    .MAX_VAL  (9999)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .grant      (grant),
    .disp_data  (disp_data),
    .disp_blank (disp_blank),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [2:0]  req;
    logic [13:0] d0;
    logic [13:0] d1;
    logic [13:0] d2;
    logic [2:0]  g;
    logic [13:0] dd;
    logic        blank;
    logic        busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] rq, input int a, input int b, input int c,
                     input logic [2:0] g, input int dd, input logic bl, input logic bz);
    vec_t v;
    v.rst_n = r;
    v.req   = rq;
    v.d0    = 14'(a);
    v.d1    = 14'(b);
    v.d2    = 14'(c);
    v.g     = g;
    v.dd    = 14'(dd);
    v.blank = bl;
    v.busy  = bz;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic [2:0] rq, input int a, input int b, input int c);
    rst_n = r;
    req   = rq;
    data0 = 14'(a);
    data1 = 14'(b);
    data2 = 14'(c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    data0 = '0;
    data1 = '0;
    data2 = '0;

    // rst  req     d0    d1     d2   grant   dd    blank busy
    add(0, 3'b000, 0,    0,     0,   3'b000, 0,    1, 0);  // reset
    add(0, 3'b000, 0,    0,     0,   3'b000, 0,    1, 0);
    add(1, 3'b001, 1234, 0,     0,   3'b001, 0,    1, 1);  // IDLE -> LOAD
    add(1, 3'b001, 1234, 0,     0,   3'b001, 1234, 0, 1);  // LOAD closes
    for (int i = 0; i < 6; i++)
      add(1, 3'b001, 1234, 0,   0,   3'b001, 1234, 0, 1);  // held, incl. self-renew
    add(0, 3'b110, 1234, 16383, 0,   3'b000, 0,    1, 0);  // reset mid-HOLD
    add(1, 3'b110, 0,    16383, 5,   3'b010, 0,    1, 1);  // source 1 first
    add(1, 3'b110, 0,    16383, 5,   3'b010, 9999, 0, 1);  // clamped
    add(1, 3'b110, 0,    0,     5,   3'b010, 0,    0, 1);
    add(1, 3'b110, 0,    0,     5,   3'b010, 0,    0, 1);
    add(1, 3'b110, 0,    0,     5,   3'b010, 0,    0, 1);
    add(1, 3'b110, 0,    0,     7,   3'b100, 0,    0, 1);  // expiry, hand over
    add(1, 3'b110, 0,    0,     7,   3'b100, 7,    0, 1);  // LOAD source 2
    add(1, 3'b100, 0,    0,     8,   3'b100, 8,    0, 1);  // refresh
    add(1, 3'b100, 0,    0,     9,   3'b100, 9,    0, 1);
    add(1, 3'b000, 0,    0,     10,  3'b100, 9,    0, 1);  // frozen
    add(1, 3'b000, 0,    0,     10,  3'b000, 9,    0, 0);  // expiry, no req
    add(1, 3'b010, 0,    9999,  0,   3'b010, 9,    0, 1);  // idle held data
    add(1, 3'b010, 0,    9999,  0,   3'b010, 9999, 0, 1);
    add(1, 3'b010, 0,    10000, 0,   3'b010, 9999, 0, 1);
    add(1, 3'b010, 0,    9998,  0,   3'b010, 9998, 0, 1);

    foreach (vecs[i]) begin
      cyc(vecs[i].rst_n, vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      check($sformatf("vec%0d grant", i), int'(grant), int'(vecs[i].g));
      check($sformatf("vec%0d disp_data", i), int'(disp_data), int'(vecs[i].dd));
      check($sformatf("vec%0d disp_blank", i), int'(disp_blank), int'(vecs[i].blank));
      check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
    end

    // Contention from reset: 001, 010, 100, 001, five cycles each, no gap.
    cyc(0, 3'b111, 100, 200, 300);
    for (int c = 1; c <= 20; c++) begin
      int slot;
      logic [2:0] eg;
      cyc(1, 3'b111, 100, 200, 300);
      slot = ((c - 1) / 5) % 3;
      eg   = 3'b001 << slot;
      check($sformatf("rr c%0d grant", c), int'(grant), int'(eg));
      check($sformatf("rr c%0d busy", c), int'(busy), 1);
      if ((c - 1) % 5 != 0)
        check($sformatf("rr c%0d disp_data", c), int'(disp_data), 100 * (slot + 1));
    end

    // Early drop: owner releases one cycle into HOLD with no other requester.
    cyc(0, 3'b000, 0, 0, 0);
    cyc(1, 3'b001, 42, 0, 0);
    check("drop grant at arb", int'(grant), 1);
    cyc(1, 3'b001, 42, 0, 0);
    check("drop load data", int'(disp_data), 42);
    cyc(1, 3'b001, 42, 0, 0);
    check("drop hold data", int'(disp_data), 42);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 3'b000, 77, 0, 0);
      check($sformatf("drop held grant %0d", i), int'(grant), 1);
      check($sformatf("drop frozen data %0d", i), int'(disp_data), 42);
    end
    cyc(1, 3'b000, 77, 0, 0);
    check("drop expiry grant", int'(grant), 0);
    check("drop expiry busy", int'(busy), 0);
    check("drop expiry data", int'(disp_data), 42);
    check("drop expiry blank", int'(disp_blank), 0);
    cyc(1, 3'b000, 77, 0, 0);
    check("drop idle data", int'(disp_data), 42);
    check("drop idle grant", int'(grant), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter HOLD_CYC, default 100: minimum cycles a grant is held in HOLD, legal range 1..1_000_000.
REQ-002 Parameter MAX_VAL, default 9999: largest value forwarded to the 4-digit display path.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  3  per-source display request, bit i for source i; level-sensitive.
REQ-006 data0, data1, data2  input  14 each  binary value offered by source 0/1/2.
REQ-007 grant  output  3  one-hot owner of the display; all-zero when unowned.
REQ-008 disp_data  output  14  registered value for the display datapath, always 0..MAX_VAL.
REQ-009 disp_blank  output  1  high when no value has been shown since reset.
REQ-010 busy  output  1  high in LOAD or HOLD.

Function
REQ-011 The FSM SHALL have three states: IDLE, LOAD, HOLD; encoding is free.
REQ-012 IDLE: if req != 0 at an edge, the block SHALL set grant to the round-robin winner and enter LOAD at that same edge; otherwise it SHALL stay in IDLE with grant = 0.
REQ-013 Round-robin: search order starts at last_owner+1 (mod 3), then last_owner+2, then last_owner; last_owner resets to 2, so source 0 wins first.
REQ-014 LOAD lasts exactly 1 cycle.
- At its closing edge: disp_data <= clamp(data_g), disp_blank <= 0, hold counter <= 0, state <= HOLD.
- last_owner SHALL be updated to the granted index at the same edge.
REQ-015 Clamp: any value greater than MAX_VAL SHALL be forwarded as MAX_VAL; values 0..MAX_VAL SHALL pass unchanged.
REQ-016 HOLD, value refresh:
- While req of the owner is high, disp_data SHALL be reloaded every cycle with clamp(data_g).
- Once the owner's req drops, disp_data SHALL freeze at the last value sampled while req was high.
REQ-017 HOLD, minimum hold: the counter SHALL increment once per cycle, and the grant SHALL NOT change before the counter reaches HOLD_CYC-1, even if the owner drops req.
REQ-018 HOLD expiry, at the edge where counter == HOLD_CYC-1, the next action SHALL be chosen by the round-robin search of REQ-013:
- Winner is a different source: grant switches to the winner, state <= LOAD, with no grant-zero gap cycle.
- Winner is the same owner (only requester): the counter restarts at 0 and the block stays in HOLD.
- No req set: grant <= 0, state <= IDLE, and disp_data and disp_blank SHALL keep their values.
REQ-019 Total ownership per grant SHALL be 1 + HOLD_CYC cycles minimum.
REQ-020 grant SHALL always be one-hot or zero, and nonzero exactly when busy = 1.
REQ-021 Latency: req rising at edge k (IDLE) -> grant at edge k -> disp_data valid after edge k+1.
REQ-022 Simultaneous requests SHALL be resolved only by REQ-013; there SHALL be no fixed priority.
REQ-023 disp_data SHALL be held in IDLE and SHALL never carry an unclamped value.

Reset
REQ-024 While rst_n = 0 at an edge, the block SHALL set:
- state <= IDLE, grant <= 0, disp_data <= 0, disp_blank <= 1, busy <= 0;
- hold counter <= 0, last_owner <= 2.
REQ-025 Reset asserted during LOAD or HOLD SHALL abort the grant at that edge, with no completion of hold and no data update.
REQ-026 After release, the first arbitration SHALL occur at the first edge with rst_n = 1 and req != 0.

Verification (HOLD_CYC = 4, MAX_VAL = 9999)
REQ-027 Single requester: req = 001, data0 = 1234 -> grant = 001 at the next edge, disp_data = 1234 one cycle later, disp_blank = 0, and the grant is held continuously while req stays 001.
REQ-028 Contention: req = 111 from reset -> grant sequence 001, 010, 100, 001, each lasting 5 cycles, with no zero-grant cycle between them.
REQ-029 Clamp: data1 = 16383 with source 1 granted -> disp_data = 9999; data1 = 0 -> disp_data = 0.
REQ-030 Early drop: source 0 granted with data0 = 42, req0 falls 1 cycle into HOLD, no other req -> disp_data frozen at 42, grant held until hold expiry, then grant = 000 and the block enters IDLE with disp_data still 42.
REQ-031 Reset mid-HOLD: rst_n = 0 for 1 cycle during HOLD -> grant = 000, disp_data = 0, disp_blank = 1 at that edge; with req = 110 afterwards -> source 1 is granted first.
REQ-032 Refresh: source 2 granted, data2 changing 7 -> 8 -> 9 on consecutive cycles -> disp_data follows 7, 8, 9, each with 1-cycle lag.
